// File: rtl/diag_cram_writer_pkg.sv
// Shared EBOX definitions used by the CRAM diagnostic writer: word widths,
// the CRADR type, diagnostic function codes and the writer's state encoding.
package diag_cram_writer_pkg;

  localparam int CRAM_W  = 80;
  localparam int CRADR_W = 11;
  localparam int EBUS_W  = 36;
  localparam int DIAG_W  = 7;

  // Vectors are declared [W-1:0]; PDP-10 bit 0 is the MSB (index W-1).
  typedef logic [CRADR_W-1:0] tCRADR;
  typedef logic [CRAM_W-1:0]  cram_word_t;
  typedef logic [EBUS_W-1:0]  ebus_word_t;
  typedef logic [DIAG_W-1:0]  diag_func_t;
  typedef logic [2:0]         step_t;

  localparam diag_func_t DIAG_LOAD_050 = 7'o050;
  localparam diag_func_t DIAG_LOAD_051 = 7'o051;
  localparam diag_func_t DIAG_LOAD_052 = 7'o052;
  localparam diag_func_t DIAG_LOAD_053 = 7'o053;
  localparam diag_func_t DIAG_LOAD_054 = 7'o054;
  localparam diag_func_t DIAG_LOAD_055 = 7'o055;
  localparam diag_func_t DIAG_LOAD_056 = 7'o056;
  localparam diag_func_t DIAG_LOAD_057 = 7'o057;
  localparam diag_func_t DIAG_READ_140 = 7'o140;
  localparam diag_func_t DIAG_READ_141 = 7'o141;
  localparam diag_func_t DIAG_READ_142 = 7'o142;
  localparam diag_func_t DIAG_READ_143 = 7'o143;
  localparam diag_func_t DIAG_READ_144 = 7'o144;
  localparam diag_func_t DIAG_READ_145 = 7'o145;
  localparam diag_func_t DIAG_READ_146 = 7'o146;
  localparam diag_func_t DIAG_READ_147 = 7'o147;

  typedef enum logic [1:0] {
    CMD_WRITE    = 2'b00,
    CMD_LOAD_ADR = 2'b01,
    CMD_READ_ADR = 2'b10,
    CMD_RSVD     = 2'b11
  } cmd_op_e;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_STROBE  = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_RSETUP  = 3'd4;
  localparam logic [2:0] ST_RSAMPLE = 3'd5;
  localparam logic [2:0] ST_RSPWAIT = 3'd6;

  // Steps 0-1 load CRADR, steps 2-5 load the four 20-bit CRAM slices.
  function automatic diag_func_t load_func(input step_t step);
    diag_func_t f;
    case (step)
      3'd0:    f = DIAG_LOAD_052;
      3'd1:    f = DIAG_LOAD_051;
      3'd2:    f = DIAG_LOAD_057;
      3'd3:    f = DIAG_LOAD_056;
      3'd4:    f = DIAG_LOAD_055;
      3'd5:    f = DIAG_LOAD_054;
      default: f = '0;
    endcase
    return f;
  endfunction

  // Read steps follow the two address-load steps.
  function automatic diag_func_t read_func(input step_t step);
    return (step == 3'd2) ? DIAG_READ_144 : DIAG_READ_145;
  endfunction

endpackage

// File: rtl/diag_step_seq.sv
// Phase generator for the CRAM writer: walks 3-cycle load steps and 2-cycle
// read steps, tracking which step (function/data slice) is current.
module diag_step_seq
  import diag_cram_writer_pkg::*;
(
  input  logic       clk,
  input  logic       RESET_n,
  input  logic       start,
  input  logic [1:0] start_op,
  input  logic       rsp_ack,
  output logic [2:0] state,
  output step_t      step
);

  logic  write_q;
  logic  read_q;
  step_t last_load_step;

  assign last_load_step = write_q ? 3'd5 : 3'd1;

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state   <= ST_IDLE;
      step    <= '0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SETUP;
            step    <= '0;
            write_q <= (start_op == CMD_WRITE);
            read_q  <= (start_op == CMD_READ_ADR);
          end
        end
        ST_SETUP:  state <= ST_STROBE;
        ST_STROBE: state <= ST_HOLD;
        ST_HOLD: begin
          if (step != last_load_step) begin
            state <= ST_SETUP;
            step  <= step + 3'd1;
          end else if (read_q) begin
            state <= ST_RSETUP;
            step  <= step + 3'd1;
          end else begin
            state <= ST_IDLE;
            step  <= '0;
          end
        end
        ST_RSETUP: state <= ST_RSAMPLE;
        ST_RSAMPLE: begin
          if (step == 3'd3) begin
            state <= ST_RSPWAIT;
            step  <= '0;
          end else begin
            state <= ST_RSETUP;
            step  <= step + 3'd1;
          end
        end
        ST_RSPWAIT: begin
          if (rsp_ack) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          step  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/diag_cram_writer.sv
// CRAM diagnostic writer: turns write / load-address / read-CRADR commands
// into EBUS diagnostic load and read function sequences toward the EBOX.
module diag_cram_writer
  import diag_cram_writer_pkg::*;
(
  input  logic                 clk,
  input  logic                 RESET_n,
  input  logic                 cmdValid,
  output logic                 cmdReady,
  input  logic [1:0]           cmdOp,
  input  logic [CRADR_W-1:0]   cmdAdr,
  input  logic [CRAM_W-1:0]    cmdData,
  output logic [DIAG_W-1:0]    diagFunc,
  output logic                 diagLoad,
  output logic                 diagRead,
  output logic [EBUS_W-1:0]    ebusOut,
  output logic                 ebusDriving,
  input  logic [EBUS_W-1:0]    ebusIn,
  output logic                 rspValid,
  input  logic                 rspReady,
  output logic [CRADR_W-1:0]   rspAdr,
  output logic                 rspPar
);

  logic       [2:0] state;
  step_t            step;
  logic             accept;
  tCRADR            cmd_adr_q;
  cram_word_t       cmd_data_q;
  tCRADR            rsp_adr_q;
  logic             rsp_par_q;
  logic             unused_ebus;

  // Only CRADR and parity come back on the low-numbered EBUS bits.
  assign unused_ebus = ^ebusIn[EBUS_W-7:0];

  // Positions are PDP-10 bit numbers mapped onto [W-1:0] vectors.
  function automatic ebus_word_t load_slice(input step_t s, input tCRADR a,
                                            input cram_word_t d);
    ebus_word_t w;
    w = '0;
    case (s)
      3'd0:    w[34:30] = a[10:6];
      3'd1:    w[35:30] = a[5:0];
      3'd2:    w[35:16] = d[79:60];
      3'd3:    w[35:16] = d[59:40];
      3'd4:    w[35:16] = d[39:20];
      3'd5:    w[35:16] = d[19:0];
      default: w = '0;
    endcase
    return w;
  endfunction

  assign cmdReady = (state == ST_IDLE);
  assign rspValid = (state == ST_RSPWAIT);
  assign accept   = cmdValid & cmdReady;
  assign rspAdr   = rsp_adr_q;
  assign rspPar   = rsp_par_q;

  diag_step_seq u_seq (
    .clk      (clk),
    .RESET_n  (RESET_n),
    .start    (accept),
    .start_op (cmdOp),
    .rsp_ack  (rspReady),
    .state    (state),
    .step     (step)
  );

  // Command capture at acceptance
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      cmd_adr_q  <= '0;
      cmd_data_q <= '0;
    end else if (accept) begin
      cmd_adr_q  <= cmdAdr;
      cmd_data_q <= cmdData;
    end
  end

  // Response capture at the end of each RSAMPLE cycle
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      rsp_adr_q <= '0;
      rsp_par_q <= 1'b0;
    end else if (state == ST_RSAMPLE) begin
      if (step == 3'd2) begin
        rsp_adr_q[5:0] <= ebusIn[35:30];
      end else begin
        rsp_par_q       <= ebusIn[35];
        rsp_adr_q[10:6] <= ebusIn[34:30];
      end
    end
  end

  // Output decode from sequencer state
  always_comb begin
    diagFunc    = '0;
    diagLoad    = 1'b0;
    diagRead    = 1'b0;
    ebusOut     = '0;
    ebusDriving = 1'b0;
    case (state)
      ST_SETUP, ST_STROBE, ST_HOLD: begin
        diagFunc    = load_func(step);
        ebusOut     = load_slice(step, cmd_adr_q, cmd_data_q);
        ebusDriving = 1'b1;
        diagLoad    = (state == ST_STROBE);
      end
      ST_RSETUP, ST_RSAMPLE: begin
        diagFunc = read_func(step);
        diagRead = 1'b1;
      end
      default: begin
        diagFunc = '0;
      end
    endcase
  end

  a_load_read_exclusive: assert property (@(posedge clk) disable iff (!RESET_n)
    !(diagLoad && diagRead));

endmodule

// File: tb/tb_diag_cram_writer.sv
// Self-checking bench for diag_cram_writer with a behavioural EBOX responder
// and a step-list reference model of the diagnostic sequences.
module tb_diag_cram_writer;

  logic        clk = 1'b0;
  logic        RESET_n;
  logic        cmdValid;
  logic        cmdReady;
  logic [1:0]  cmdOp;
  logic [10:0] cmdAdr;
  logic [79:0] cmdData;
  logic [6:0]  diagFunc;
  logic        diagLoad;
  logic        diagRead;
  logic [35:0] ebusOut;
  logic        ebusDriving;
  logic [35:0] ebusIn;
  logic        rspValid;
  logic        rspReady;
  logic [10:0] rspAdr;
  logic        rspPar;

  logic [10:0] ebox_cradr;
  logic        ebox_par;
  logic [47:0] obs;
  logic [47:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  diag_cram_writer dut (
    .clk         (clk),
    .RESET_n     (RESET_n),
    .cmdValid    (cmdValid),
    .cmdReady    (cmdReady),
    .cmdOp       (cmdOp),
    .cmdAdr      (cmdAdr),
    .cmdData     (cmdData),
    .diagFunc    (diagFunc),
    .diagLoad    (diagLoad),
    .diagRead    (diagRead),
    .ebusOut     (ebusOut),
    .ebusDriving (ebusDriving),
    .ebusIn      (ebusIn),
    .rspValid    (rspValid),
    .rspReady    (rspReady),
    .rspAdr      (rspAdr),
    .rspPar      (rspPar)
  );

  // EBOX model: answers read functions 144/145 with its current CRADR and parity.
  always_comb begin
    ebusIn = '0;
    if (diagRead && diagFunc == 7'o144) ebusIn = {ebox_cradr[5:0], 30'b0};
    else if (diagRead && diagFunc == 7'o145) ebusIn = {ebox_par, ebox_cradr[10:6], 30'b0};
  end

  assign obs = {diagFunc, diagLoad, diagRead, ebusDriving, ebusOut, cmdReady, rspValid};

  function automatic logic [47:0] mk(input logic [6:0] fn, input logic ld, input logic rd,
                                     input logic drv, input logic [35:0] w,
                                     input logic rdy, input logic rv);
    return {fn, ld, rd, drv, w, rdy, rv};
  endfunction

  localparam logic [47:0] IDLE_V = {7'd0, 3'b000, 36'd0, 2'b10};
  localparam logic [47:0] RSPW_V = {7'd0, 3'b000, 36'd0, 2'b01};

  // Reference: list the diagnostic steps a command implies, then expand each
  // load step into SETUP/STROBE/HOLD and each read step into two cycles.
  task automatic build_trace(input logic [1:0] op, input logic [10:0] adr, input logic [79:0] data);
    logic [6:0]  fn[$];
    logic [35:0] wd[$];
    logic        rd[$];
    exp_q.delete();
    fn.push_back(7'o052); wd.push_back({1'b0, adr[10:6], 30'b0}); rd.push_back(1'b0);
    fn.push_back(7'o051); wd.push_back({adr[5:0], 30'b0});        rd.push_back(1'b0);
    if (op == 2'b00) begin
      fn.push_back(7'o057); wd.push_back({data[79:60], 16'b0}); rd.push_back(1'b0);
      fn.push_back(7'o056); wd.push_back({data[59:40], 16'b0}); rd.push_back(1'b0);
      fn.push_back(7'o055); wd.push_back({data[39:20], 16'b0}); rd.push_back(1'b0);
      fn.push_back(7'o054); wd.push_back({data[19:0], 16'b0});  rd.push_back(1'b0);
    end else if (op == 2'b10) begin
      fn.push_back(7'o144); wd.push_back(36'd0); rd.push_back(1'b1);
      fn.push_back(7'o145); wd.push_back(36'd0); rd.push_back(1'b1);
    end
    foreach (fn[i]) begin
      if (!rd[i]) begin
        exp_q.push_back(mk(fn[i], 1'b0, 1'b0, 1'b1, wd[i], 1'b0, 1'b0));
        exp_q.push_back(mk(fn[i], 1'b1, 1'b0, 1'b1, wd[i], 1'b0, 1'b0));
        exp_q.push_back(mk(fn[i], 1'b0, 1'b0, 1'b1, wd[i], 1'b0, 1'b0));
      end else begin
        exp_q.push_back(mk(fn[i], 1'b0, 1'b1, 1'b0, 36'd0, 1'b0, 1'b0));
        exp_q.push_back(mk(fn[i], 1'b0, 1'b1, 1'b0, 36'd0, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic check_trace(input string name, input int ncyc);
    for (int i = 0; i < ncyc && i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i + 1, obs, exp_q[i]);
      end
    end
  endtask

  task automatic expect_obs(input string name, input logic [47:0] e);
    @(negedge clk);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, obs, e);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [10:0] adr, input logic [79:0] data);
    int waited = 0;
    @(negedge clk);
    while (!cmdReady && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!cmdReady) begin
      errors++;
      $display("FAIL issue_ready_timeout: got cmdReady=%b expected 1", cmdReady);
    end
    cmdValid = 1'b1; cmdOp = op; cmdAdr = adr; cmdData = data;
    @(posedge clk);
    #1 cmdValid = 1'b0;
  endtask

  // Full command: issue, compare every busy cycle, then the response handshake.
  task automatic run_cmd(input string name, input logic [1:0] op, input logic [10:0] adr,
                         input logic [79:0] data, input int hold, input logic stray);
    logic [31:0] r;
    issue(op, adr, data);
    build_trace(op, adr, data);
    if (op != 2'b10) begin
      r = $urandom();
      rspReady = r[0];
    end
    check_trace(name, exp_q.size());
    rspReady = 1'b0;
    if (op == 2'b10) begin
      expect_obs({name, "_rspvalid"}, RSPW_V);
      checks++;
      if (rspAdr !== ebox_cradr || rspPar !== ebox_par) begin
        errors++;
        $display("FAIL %s_rspdata: got adr=%o par=%b expected adr=%o par=%b",
                 name, rspAdr, rspPar, ebox_cradr, ebox_par);
      end
      for (int h = 0; h < hold; h++) begin
        r = $urandom();
        cmdValid = stray; cmdOp = r[1:0]; cmdAdr = r[12:2];
        expect_obs({name, "_hold"}, RSPW_V);
        checks++;
        if (rspAdr !== ebox_cradr || rspPar !== ebox_par) begin
          errors++;
          $display("FAIL %s_hold_data: got adr=%o par=%b expected adr=%o par=%b",
                   name, rspAdr, rspPar, ebox_cradr, ebox_par);
        end
      end
      cmdValid = 1'b0;
      rspReady = 1'b1;
      @(posedge clk);
      #1 rspReady = 1'b0;
    end
    expect_obs({name, "_idle"}, IDLE_V);
  endtask

  task automatic test_reset;
    RESET_n = 1'b0; cmdValid = 1'b0; cmdOp = 2'b00; cmdAdr = '0; cmdData = '0;
    rspReady = 1'b0; ebox_cradr = '0; ebox_par = 1'b0;
    #3;
    checks++;
    if (obs !== IDLE_V || rspAdr !== 11'd0 || rspPar !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got %h adr=%o par=%b expected %h adr=0 par=0", obs, rspAdr, rspPar, IDLE_V);
    end
    // Release and present a command for the very first edge after release.
    @(negedge clk);
    RESET_n = 1'b1;
    cmdValid = 1'b1; cmdOp = 2'b01; cmdAdr = 11'o0525; cmdData = '0;
    @(posedge clk);
    #1 cmdValid = 1'b0;
    build_trace(2'b01, 11'o0525, '0);
    check_trace("first_edge_accept", exp_q.size());
    expect_obs("first_edge_idle", IDLE_V);
  endtask

  task automatic test_write;
    run_cmd("write_dir", 2'b00, 11'o1234, 80'h0123456789ABCDEF0123, 0, 1'b0);
  endtask

  task automatic test_read;
    ebox_cradr = 11'o3777; ebox_par = 1'b1;
    run_cmd("read_dir", 2'b10, 11'o0000, '0, 0, 1'b0);
  endtask

  task automatic test_rsp_hold;
    ebox_cradr = 11'o1526; ebox_par = 1'b0;
    run_cmd("read_hold", 2'b10, 11'o0421, '0, 5, 1'b1);
  endtask

  task automatic test_reserved_op;
    run_cmd("op11", 2'b11, 11'o0777, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 0, 1'b0);
    run_cmd("loadadr", 2'b01, 11'o2461, '0, 0, 1'b0);
  endtask

  task automatic test_reset_mid;
    issue(2'b00, 11'o7654, 80'hFEDC_BA98_7654_3210_ABCD);
    build_trace(2'b00, 11'o7654, 80'hFEDC_BA98_7654_3210_ABCD);
    check_trace("rst_mid_pre", 8);
    #2 RESET_n = 1'b0;
    #1;
    checks++;
    if (obs !== IDLE_V || rspAdr !== 11'd0 || rspPar !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: got %h adr=%o par=%b expected %h adr=0 par=0", obs, rspAdr, rspPar, IDLE_V);
    end
    @(posedge clk);
    #2 RESET_n = 1'b1;
    for (int i = 0; i < 6; i++) expect_obs("rst_mid_after", IDLE_V);
  endtask

  task automatic test_back_to_back;
    logic [79:0] d1, d2;
    logic [95:0] t;
    int waited = 0;
    t = {$urandom(), $urandom(), $urandom()}; d1 = t[79:0];
    t = {$urandom(), $urandom(), $urandom()}; d2 = t[79:0];
    @(negedge clk);
    while (!cmdReady && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    cmdValid = 1'b1; cmdOp = 2'b00; cmdAdr = 11'o0123; cmdData = d1;
    @(posedge clk);
    #1 cmdAdr = 11'o6543; cmdData = d2;
    build_trace(2'b00, 11'o0123, d1);
    check_trace("b2b_first", exp_q.size());
    expect_obs("b2b_ready", IDLE_V);
    @(posedge clk);
    #1 cmdValid = 1'b0;
    build_trace(2'b00, 11'o6543, d2);
    check_trace("b2b_second", exp_q.size());
    expect_obs("b2b_idle", IDLE_V);
  endtask

  task automatic test_random;
    logic [31:0] r;
    logic [95:0] t;
    for (int n = 0; n < 16; n++) begin
      r = $urandom();
      t = {$urandom(), $urandom(), $urandom()};
      ebox_cradr = r[23:13]; ebox_par = r[24];
      run_cmd("random", r[1:0], r[12:2], t[79:0], int'(r[27:25]) % 4, r[28]);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_rsp_hold();
    test_reserved_op();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/diag_cram_writer.md
DIAG_CRAM_WRITER -- requirements
Module: diag_cram_writer

Interface
REQ-001 The block SHALL declare its ports, clock and reset first, as: clk  in  1  single clock; all state on its rising edge.
REQ-002 The block SHALL declare: RESET_n  in  1  asynchronous, active-low reset.
REQ-003 The block SHALL declare: cmdValid  in  1  command offered.
REQ-004 The block SHALL declare: cmdReady  out  1  block idle and accepting.
REQ-005 The block SHALL declare: cmdOp  in  2  00 = write CRAM word, 01 = load address only, 10 = read CRADR, 11 = reserved (treated as 01).
REQ-006 The block SHALL declare: cmdAdr  in  11  CRAM address [0:10] (tCRADR).
REQ-007 The block SHALL declare: cmdData  in  80  CRAM word [0:79].
REQ-008 The block SHALL declare: diagFunc  out  7  diagnostic function code DIAG[0:6].
REQ-009 The block SHALL declare: diagLoad  out  1  load-function strobe (05x group).
REQ-010 The block SHALL declare: diagRead  out  1  read-function enable (14x group).
REQ-011 The block SHALL declare: ebusOut  out  36  EBUS data [0:35] driven toward the EBOX.
REQ-012 The block SHALL declare: ebusDriving  out  1  ebusOut is valid.
REQ-013 The block SHALL declare: ebusIn  in  36  EBUS data returned by the EBOX.
REQ-014 The block SHALL declare: rspValid  out  1  read result available.
REQ-015 The block SHALL declare: rspReady  in  1  result consumed.
REQ-016 The block SHALL declare: rspAdr  out  11  CRADR read back.
REQ-017 The block SHALL declare: rspPar  out  1  DISP parity read back.

Function
REQ-018 cmdReady SHALL be 1 only in IDLE with rspValid 0; a command SHALL be accepted on a clk edge where cmdValid & cmdReady, with cmdOp/cmdAdr/cmdData captured at that edge.
REQ-019 Load step SHALL take 3 cycles: SETUP (diagFunc, ebusOut, ebusDriving=1, diagLoad=0), STROBE (diagLoad=1), HOLD (diagLoad=0, data and function still driven).
REQ-020 Address load SHALL be two load steps: function 052 with ebusOut[1:5]=adr[0:4], then 051 with ebusOut[0:5]=adr[5:10]; all other ebusOut bits 0.
REQ-021 Write SHALL be: address load, then 057 (ebusOut[0:19]=data[0:19]), 056 (data[20:39]), 055 (data[40:59]), 054 (data[60:79]); 18 cycles from acceptance to return to IDLE.
REQ-022 Load-address-only SHALL take 6 cycles.
REQ-023 Read step SHALL take 2 cycles: RSETUP (diagFunc set, diagRead=1, ebusDriving=0), RSAMPLE (diagRead=1, ebusIn captured at end of cycle).
REQ-024 Read SHALL be: address load, then read 144 (rspAdr[5:10]=ebusIn[0:5]), then read 145 (rspPar=ebusIn[0], rspAdr[0:4]=ebusIn[1:5]); rspValid SHALL rise the cycle after the last sample (11 cycles after acceptance).
REQ-025 rspValid SHALL hold, with rspAdr/rspPar stable, until a clk edge with rspReady=1; that edge SHALL clear it; rspReady while rspValid=0 SHALL be ignored.
REQ-026 The state machine SHALL have states IDLE, SETUP, STROBE, HOLD, RSETUP, RSAMPLE, RSPWAIT; a step counter (0..5) SHALL select the function and data slice.
REQ-027 Outside SETUP/STROBE/HOLD, ebusDriving SHALL be 0 and ebusOut all 0; outside RSETUP/RSAMPLE, diagRead SHALL be 0; in IDLE/RSPWAIT, diagFunc SHALL be 0.
REQ-028 diagLoad and diagRead SHALL never both be 1 in any cycle.
REQ-029 cmdValid during a busy or RSPWAIT cycle SHALL NOT be accepted or alter state.

Reset
REQ-030 RESET_n low SHALL immediately, without clk, force IDLE, step counter 0, cmdReady 1, and diagLoad, diagRead, ebusDriving, rspValid 0, with ebusOut, diagFunc, rspAdr, rspPar all 0.
REQ-031 Reset mid-command SHALL abandon the sequence with no further strobes after deassertion; the first clk edge after release SHALL be able to accept a command.

Structure
REQ-032 Diagnostic function codes (050-057, 140-147), the CRAM word width (80) and tCRADR SHALL live in the shared EBOX package, not locally.
REQ-033 One sub-module, diag_step_seq (the 3-cycle load / 2-cycle read phase generator), is natural; otherwise the block SHALL be flat.

Verification
REQ-034 Bench SHALL cover: write, adr=11'o1234, data=80'h0123456789ABCDEF0123 -> functions 052,051,057,056,055,054 in order, one diagLoad pulse each 3 cycles apart, correct slices, cmdReady back at cycle 18.
REQ-035 Bench SHALL cover: read, adr=11'o0000, EBOX model returns CRADR=11'o3777, parity 1 -> rspValid at cycle 11, rspAdr=11'o3777, rspPar=1.
REQ-036 Bench SHALL cover: read with rspReady held low 5 cycles -> rspValid and data stable, cmdReady 0, a new cmdValid is ignored.
REQ-037 Bench SHALL cover: RESET_n pulse low in the 057 STROBE cycle -> all outputs 0 asynchronously and no diagLoad after release.
REQ-038 Bench SHALL cover: cmdOp=11, adr=11'o0777 -> same as load-address-only (052,051) and 6 cycles.
REQ-039 Bench SHALL cover: back-to-back writes with cmdValid held high -> second command accepted the cycle cmdReady returns, no overlap of strobes.
